// File: rtl/buzz_pkg.sv
// rtl/buzz_pkg.sv - shared state encoding, zone constants and priority encoder for the piezo tone driver
package buzz_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        BEEP_ON  = 2'd1,
        BEEP_OFF = 2'd2,
        COOL     = 2'd3
    } state_e;

    localparam logic [1:0] ZONE0     = 2'd0;
    localparam logic [1:0] ZONE1     = 2'd1;
    localparam logic [1:0] ZONE2     = 2'd2;
    localparam logic [1:0] ZONE_NONE = 2'd3;

    // Lowest set bit wins: zone 0 is the most urgent alarm.
    function automatic logic [1:0] prio_enc(input logic [2:0] v);
        if (v[0]) begin
            return ZONE0;
        end else if (v[1]) begin
            return ZONE1;
        end else if (v[2]) begin
            return ZONE2;
        end else begin
            return ZONE_NONE;
        end
    endfunction

endpackage

// File: rtl/buzz_tick_gen.sv
// rtl/buzz_tick_gen.sv - cadence prescaler producing one tick every PRESCALE enabled clk cycles
module buzz_tick_gen #(
    parameter int unsigned PRESCALE = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    assign tick = en & (cnt_q == 8'(PRESCALE - 1));

    // Count 0..PRESCALE-1; a clear restarts the cadence phase at 0.
    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (cnt_q == 8'(PRESCALE - 1)) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    // Prescaler register, frozen while disabled.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/buzz_tone_driver.sv
// rtl/buzz_tone_driver.sv - alarm-to-beep-cadence piezo driver; BUZZ_PREEMPT_EN enables priority preemption
module buzz_tone_driver
    import buzz_pkg::*;
#(
    parameter int unsigned PRESCALE   = 16,
    parameter int unsigned TONE0_HALF = 3,
    parameter int unsigned TONE1_HALF = 5,
    parameter int unsigned TONE2_HALF = 7,
    parameter int unsigned ON_TICKS   = 4,
    parameter int unsigned OFF_TICKS  = 2,
    parameter int unsigned NUM_BEEPS  = 3,
    parameter int unsigned COOL_TICKS = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [2:0] alarm_in,
    input  logic       ack,
    output logic       spk_out,
    output logic [2:0] led,
    output logic       busy,
    output logic [1:0] active_ch
);

    generate
        if (PRESCALE < 2 || PRESCALE > 255 ||
            TONE0_HALF < 1 || TONE0_HALF > 7 ||
            TONE1_HALF < 1 || TONE1_HALF > 7 ||
            TONE2_HALF < 1 || TONE2_HALF > 7 ||
            ON_TICKS < 1 || ON_TICKS > 15 ||
            OFF_TICKS < 1 || OFF_TICKS > 15 ||
            NUM_BEEPS < 1 || NUM_BEEPS > 7 ||
            COOL_TICKS < 1 || COOL_TICKS > 15) begin : g_param_check
            $error("buzz_tone_driver: parameter out of range");
        end
    endgenerate

    state_e     state_q, state_d;
    logic [2:0] alarm_q, alarm_d;
    logic [2:0] pending_q, pending_d;
    logic [1:0] active_ch_q, active_ch_d;
    logic [2:0] beep_cnt_q, beep_cnt_d;
    logic [3:0] tick_cnt_q, tick_cnt_d;
    logic [2:0] tone_cnt_q, tone_cnt_d;
    logic       tone_q, tone_d;

    logic [2:0] rise;
    logic [2:0] cand;
    logic [1:0] serve_ch;
    logic [3:0] tick_limit;
    logic       last_tick;
    logic       restart;
    logic       state_chg;
    logic       tick;
    logic       tick_clr;
    logic [2:0] tone_half;

    assign tick_clr = (state_q == IDLE) | state_chg;

    buzz_tick_gen #(
        .PRESCALE(PRESCALE)
    ) u_tick_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (ena),
        .clr  (tick_clr),
        .tick (tick)
    );

    // Tone half-period of the zone being served.
    always_comb begin
        case (active_ch_q)
            ZONE1:   tone_half = 3'(TONE1_HALF);
            ZONE2:   tone_half = 3'(TONE2_HALF);
            default: tone_half = 3'(TONE0_HALF);
        endcase
    end

    // Service FSM: latch rising alarms, pick by priority, walk the beep cadence.
    always_comb begin
        alarm_d     = alarm_in;
        rise        = alarm_in & ~alarm_q;
        cand        = pending_q | rise;
        serve_ch    = prio_enc(cand);
        state_d     = state_q;
        active_ch_d = active_ch_q;
        pending_d   = cand;
        beep_cnt_d  = beep_cnt_q;
        restart     = 1'b0;
        case (state_q)
            BEEP_ON:  tick_limit = 4'(ON_TICKS - 1);
            BEEP_OFF: tick_limit = 4'(OFF_TICKS - 1);
            default:  tick_limit = 4'(COOL_TICKS - 1);
        endcase
        last_tick = tick & (tick_cnt_q == tick_limit);
        case (state_q)
            IDLE: begin
                if (cand != 3'b000) begin
                    state_d     = BEEP_ON;
                    active_ch_d = serve_ch;
                    pending_d   = cand & ~(3'b001 << serve_ch);
                end
            end
            BEEP_ON: begin
                if (last_tick) begin
                    beep_cnt_d = beep_cnt_q + 3'd1;
                    state_d    = (beep_cnt_d == 3'(NUM_BEEPS)) ? COOL : BEEP_OFF;
                end
            end
            BEEP_OFF: begin
                if (last_tick) begin
                    state_d = BEEP_ON;
                end
            end
            COOL: begin
                if (last_tick) begin
                    state_d     = IDLE;
                    active_ch_d = ZONE_NONE;
                    beep_cnt_d  = '0;
                end
            end
            default: state_d = IDLE;
        endcase
`ifdef BUZZ_PREEMPT_EN
        // A more urgent zone takes over on a cadence tick; the displaced zone is re-queued in full.
        if ((state_q == BEEP_ON || state_q == BEEP_OFF) && tick && (serve_ch < active_ch_q)) begin
            state_d     = BEEP_ON;
            active_ch_d = serve_ch;
            beep_cnt_d  = '0;
            restart     = 1'b1;
            pending_d   = (cand & ~(3'b001 << serve_ch)) | (3'b001 << active_ch_q);
        end
`endif
        if (ack) begin
            state_d     = IDLE;
            active_ch_d = ZONE_NONE;
            pending_d   = '0;
            beep_cnt_d  = '0;
            restart     = 1'b0;
        end
        state_chg = (state_d != state_q) | restart;
    end

    // Per-state tick count and tone square wave, both restarted on any state entry.
    always_comb begin
        tick_cnt_d = tick_cnt_q;
        tone_cnt_d = tone_cnt_q;
        tone_d     = tone_q;
        if (state_chg || ack) begin
            tick_cnt_d = '0;
            tone_cnt_d = '0;
            tone_d     = 1'b0;
        end else begin
            if (tick) begin
                tick_cnt_d = tick_cnt_q + 4'd1;
            end
            if (state_q == BEEP_ON) begin
                if (tone_cnt_q == tone_half - 3'd1) begin
                    tone_cnt_d = '0;
                    tone_d     = ~tone_q;
                end else begin
                    tone_cnt_d = tone_cnt_q + 3'd1;
                end
            end
        end
    end

    // State registers; everything freezes while ena is low.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            alarm_q     <= '0;
            pending_q   <= '0;
            active_ch_q <= ZONE_NONE;
            beep_cnt_q  <= '0;
            tick_cnt_q  <= '0;
            tone_cnt_q  <= '0;
            tone_q      <= 1'b0;
        end else if (ena) begin
            state_q     <= state_d;
            alarm_q     <= alarm_d;
            pending_q   <= pending_d;
            active_ch_q <= active_ch_d;
            beep_cnt_q  <= beep_cnt_d;
            tick_cnt_q  <= tick_cnt_d;
            tone_cnt_q  <= tone_cnt_d;
            tone_q      <= tone_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign active_ch = active_ch_q;
    assign led       = busy ? (3'b001 << active_ch_q) : 3'b000;
    assign spk_out   = ena & (state_q == BEEP_ON) & tone_q;

endmodule

// File: tb/tb_buzz_tone_driver.sv
// tb/tb_buzz_tone_driver.sv - self-checking bench for buzz_tone_driver against a service-timeline model
module tb_buzz_tone_driver;

    localparam int P         = 4;
    localparam int ONT       = 2;
    localparam int OFFT      = 1;
    localparam int NB        = 2;
    localparam int CT        = 2;
    localparam int H0        = 2;
    localparam int H1        = 5;
    localparam int H2        = 7;
    localparam int PERIOD    = (ONT + OFFT) * P;
    localparam int BEEPS_END = NB * ONT * P + (NB - 1) * OFFT * P;
    localparam int TOTAL     = BEEPS_END + CT * P;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b1;
    logic [2:0] alarm_in = 3'b000;
    logic       ack = 1'b0;
    logic       spk_out;
    logic [2:0] led;
    logic       busy;
    logic [1:0] active_ch;

    int n_chk = 0;
    int n_fail = 0;

    bit       m_busy;
    int       m_zone;
    int       m_t;
    bit [2:0] m_pend;
    bit [2:0] m_prev;

    always #5 clk = ~clk;

    buzz_tone_driver #(
        .PRESCALE  (P),
        .TONE0_HALF(H0),
        .TONE1_HALF(H1),
        .TONE2_HALF(H2),
        .ON_TICKS  (ONT),
        .OFF_TICKS (OFFT),
        .NUM_BEEPS (NB),
        .COOL_TICKS(CT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .ena      (ena),
        .alarm_in (alarm_in),
        .ack      (ack),
        .spk_out  (spk_out),
        .led      (led),
        .busy     (busy),
        .active_ch(active_ch)
    );

    function automatic int lowest(input bit [2:0] v);
        for (int i = 0; i < 3; i++) begin
            if (v[i]) return i;
        end
        return 3;
    endfunction

    function automatic int half_of(input int z);
        if (z == 1) return H1;
        if (z == 2) return H2;
        return H0;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_zone = 3;
        m_t    = 0;
        m_pend = '0;
        m_prev = '0;
    endtask

    // One enabled clock edge of the reference: a service is a fixed timeline of TOTAL cycles.
    task automatic model_step();
        bit [2:0] rise;
        bit [2:0] cand;
        int       z;
        int       t_old;
        rise   = alarm_in & ~m_prev;
        m_prev = alarm_in;
        if (ack) begin
            m_busy = 1'b0;
            m_pend = '0;
            return;
        end
        cand   = m_pend | rise;
        m_pend = cand;
        if (!m_busy) begin
            if (cand != 3'b000) begin
                z         = lowest(cand);
                m_busy    = 1'b1;
                m_zone    = z;
                m_t       = 0;
                m_pend[z] = 1'b0;
            end
            return;
        end
        t_old = m_t;
        m_t   = m_t + 1;
`ifdef BUZZ_PREEMPT_EN
        if (t_old < BEEPS_END && (t_old % P) == P - 1 && lowest(cand) < m_zone) begin
            z              = lowest(cand);
            m_pend[z]      = 1'b0;
            m_pend[m_zone] = 1'b1;
            m_zone         = z;
            m_t            = 0;
            return;
        end
`endif
        if (m_t == TOTAL) m_busy = 1'b0;
    endtask

    task automatic check_model(input string tag);
        logic [7:0] e_ch;
        logic [7:0] e_led;
        logic [7:0] e_spk;
        int         pos;
        e_ch  = m_busy ? 8'(m_zone) : 8'd3;
        e_led = m_busy ? 8'(1 << m_zone) : 8'd0;
        pos   = m_t % PERIOD;
        e_spk = 8'd0;
        if (m_busy && ena && m_t < BEEPS_END && pos < ONT * P)
            e_spk = 8'((pos / half_of(m_zone)) % 2);
        chk({tag, ":busy"}, {7'd0, busy}, {7'd0, m_busy});
        chk({tag, ":active_ch"}, {6'd0, active_ch}, e_ch);
        chk({tag, ":led"}, {5'd0, led}, e_led);
        chk({tag, ":spk_out"}, {7'd0, spk_out}, e_spk);
    endtask

    task automatic tick_cycle(input string tag);
        @(posedge clk);
        if (ena) model_step();
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        int         cnt;
        int         first_z2;
        logic [7:0] pat;

        model_reset();
        repeat (2) @(negedge clk);
        chk("reset:busy", {7'd0, busy}, 8'd0);
        chk("reset:led", {5'd0, led}, 8'd0);
        chk("reset:spk_out", {7'd0, spk_out}, 8'd0);
        chk("reset:active_ch", {6'd0, active_ch}, 8'd3);
        rst_n = 1'b1;
        tick_cycle("idle");

        // 1: zone 0 held high -> exactly one 28-cycle service, tone 0011 pattern
        alarm_in = 3'b001;
        cnt = 0;
        pat = '0;
        for (int i = 0; i < 40; i++) begin
            tick_cycle("t1");
            if (busy) cnt++;
            if (i < 8) pat = {pat[6:0], spk_out};
        end
        chk("t1:busy_cycles", 8'(cnt), 8'd28);
        chk("t1:tone_pattern", pat, 8'b0011_0011);

        // 2: zones 2 and 1 rise together -> zone 1 first, zone 2 one idle cycle after
        alarm_in = 3'b000;
        tick_cycle("t2");
        alarm_in = 3'b110;
        tick_cycle("t2");
        chk("t2:first_ch", {6'd0, active_ch}, 8'd1);
        first_z2 = -1;
        for (int i = 1; i < 70; i++) begin
            tick_cycle("t2");
            if (active_ch == 2'd2 && first_z2 < 0) first_z2 = i;
        end
        chk("t2:zone2_start", 8'(first_z2), 8'd29);

        // 3: ack mid-BEEP_ON with zone 2 pending
        alarm_in = 3'b000;
        tick_cycle("t3");
        alarm_in = 3'b110;
        repeat (4) tick_cycle("t3");
        ack = 1'b1;
        tick_cycle("t3");
        ack = 1'b0;
        chk("t3:busy_after_ack", {7'd0, busy}, 8'd0);
        chk("t3:ch_after_ack", {6'd0, active_ch}, 8'd3);
        chk("t3:spk_after_ack", {7'd0, spk_out}, 8'd0);
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            tick_cycle("t3");
            if (busy) cnt++;
        end
        chk("t3:no_service", 8'(cnt), 8'd0);

        // 4: ena low for 10 cycles in BEEP_OFF stretches the service by 10
        alarm_in = 3'b000;
        tick_cycle("t4");
        alarm_in = 3'b001;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick_cycle("t4");
            if (busy) cnt++;
        end
        ena = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick_cycle("t4_frozen");
            if (busy) cnt++;
        end
        ena = 1'b1;
        for (int i = 0; i < 40; i++) begin
            tick_cycle("t4");
            if (busy) cnt++;
        end
        chk("t4:busy_cycles", 8'(cnt), 8'd38);

        // 5: asynchronous reset mid-BEEP_ON
        alarm_in = 3'b000;
        tick_cycle("t5");
        alarm_in = 3'b100;
        repeat (3) tick_cycle("t5");
        #2 rst_n = 1'b0;
        #1;
        chk("t5:busy_async", {7'd0, busy}, 8'd0);
        chk("t5:led_async", {5'd0, led}, 8'd0);
        chk("t5:spk_async", {7'd0, spk_out}, 8'd0);
        chk("t5:ch_async", {6'd0, active_ch}, 8'd3);
        alarm_in = 3'b000;
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick_cycle("t5");
            if (busy) cnt++;
        end
        chk("t5:stays_idle", 8'(cnt), 8'd0);

        // random alarms, rare acks and enable gaps against the model
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) alarm_in = 3'($urandom_range(0, 7));
            ack = ($urandom_range(0, 63) == 0);
            ena = ($urandom_range(0, 15) != 0);
            tick_cycle("rand");
        end
        ack = 1'b0;
        ena = 1'b1;

`ifdef BUZZ_PREEMPT_EN
        // 6: zone 0 preempts zone 2 at the next tick; zone 2 replays in full later
        ack = 1'b1;
        alarm_in = 3'b000;
        tick_cycle("t6");
        ack = 1'b0;
        tick_cycle("t6");
        alarm_in = 3'b100;
        repeat (3) tick_cycle("t6");
        alarm_in = 3'b101;
        first_z2 = -1;
        for (int j = 0; j < 8; j++) begin
            tick_cycle("t6");
            if (active_ch == 2'd0 && first_z2 < 0) first_z2 = j;
        end
        chk("t6:preempt_cycle", 8'(first_z2), 8'd1);
        cnt = 0;
        for (int i = 0; i < 80; i++) begin
            tick_cycle("t6");
            if (active_ch == 2'd2) cnt++;
        end
        chk("t6:zone2_replay", 8'(cnt), 8'(TOTAL));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/buzz_tone_driver.md
Name: buzz_tone_driver

Overview:
- Downstream of the sensor-debounce/alarm-select stage. Consumes its three one-hot alarm-level outputs.
- Turns each alarm into an audible, zone-specific beep cadence on a single piezo pin, plus per-zone indicator LEDs.
- Latches alarms as pending, serves them one at a time by fixed priority, and accepts an operator acknowledge.

Parameters:
- PRESCALE, 16, clk cycles per cadence tick (2..255).
- TONE0_HALF, 3, tone half-period in clk cycles, zone 0.
- TONE1_HALF, 5, tone half-period in clk cycles, zone 1.
- TONE2_HALF, 7, tone half-period in clk cycles, zone 2.
- ON_TICKS, 4, ticks per beep-on interval (1..15).
- OFF_TICKS, 2, ticks per beep-off gap (1..15).
- NUM_BEEPS, 3, beeps per alarm (1..7).
- COOL_TICKS, 8, silent ticks after last beep before next service (1..15).

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- ena  in  1  global enable; low freezes all state
- alarm_in  in  3  one-hot alarm levels from upstream, already synchronous to clk
- ack  in  1  operator acknowledge, 1-cycle pulse
- spk_out  out  1  piezo square wave
- led  out  3  one-hot zone indicator; bit of the active zone while busy
- busy  out  1  state != IDLE
- active_ch  out  2  zone being served; 2'd3 when idle

Behaviour:
- Reset values: all outputs 0, except active_ch = 3. State IDLE, pending = 0, alarm_q = 0, all counters 0, tone_q = 0.
- Edge detect: rise = alarm_in & ~alarm_q; alarm_q <= alarm_in every enabled cycle. A level held high produces exactly one request.
- Pending update: pending <= pending | rise, minus the bit being served.
- States: IDLE, BEEP_ON, BEEP_OFF, COOL.
- IDLE:
  - Candidate set = pending | rise. Zone 0 has highest priority, zone 2 lowest.
  - If the set is non-empty, the next edge enters BEEP_ON, latches active_ch and clears that pending bit.
  - Latency: busy is high the cycle after the first edge that samples alarm_in high.
- Tick generator: counter 0..PRESCALE-1 emits tick when the count equals PRESCALE-1. It is held at 0 in IDLE and cleared on every state change.
- BEEP_ON:
  - Lasts ON_TICKS ticks = ON_TICKS*PRESCALE cycles.
  - tone_q is cleared on entry and toggles every TONEn_HALF cycles of the active zone.
  - spk_out = tone_q, combinational from registers; spk_out = 0 in all other states.
  - On the last tick, beep_cnt increments. If beep_cnt == NUM_BEEPS, go to COOL; else go to BEEP_OFF.
- BEEP_OFF: lasts OFF_TICKS ticks, then returns to BEEP_ON.
- COOL: lasts COOL_TICKS ticks, then IDLE. beep_cnt is cleared.
- Pending bits may become ready again during COOL. They are served only from IDLE; there is no back-to-back service without COOL.
- ack:
  - From any state, the next edge forces IDLE and clears pending, beep_cnt and tone_q.
  - A rise in the same cycle as ack is dropped.
- ena low: all registers hold, alarm_q included; spk_out is forced 0; led, busy and active_ch hold.
- Re-arm: a rise of the zone currently being served sets its pending bit, so it is served again after COOL.
- Counter widths: beep_cnt 3 bits, tick counter 4 bits, tone counter 3 bits.
- Overflow is impossible within the parameter ranges. Out-of-range parameters are flagged by an elaboration-time check.

Optional Feature:
- Macro BUZZ_PREEMPT_EN.
- With it defined:
  - A pending zone with higher priority than active_ch aborts the current service at the next BEEP_ON/BEEP_OFF tick boundary.
  - The higher zone enters BEEP_ON immediately, with beep_cnt cleared and no COOL.
  - The preempted zone's pending bit is re-set so it is replayed in full later.
  - Preemption is never taken during COOL.
- Without it: strictly non-preemptive as above.

Decomposition:
- Package buzz_pkg:
  - state enum (IDLE, BEEP_ON, BEEP_OFF, COOL);
  - zone index constants ZONE0..ZONE2 and ZONE_NONE = 2'd3;
  - a priority-encode function returning the lowest set bit index.
- One sub-module, buzz_tick_gen: prescaler with synchronous clear and enable, producing the tick pulse.
- Tone counter and FSM stay in the top.

Test Plan:
Use PRESCALE=4, ON_TICKS=2, OFF_TICKS=1, NUM_BEEPS=2, COOL_TICKS=2, TONE0_HALF=2.
1. alarm_in=3'b001 held high:
   - busy rises 1 cycle later and stays high 28 cycles (ON 8, OFF 4, ON 8, COOL 8);
   - led=001; spk_out pattern 0011 repeated during each ON;
   - no second service while the level stays high.
2. alarm_in 3'b100 and 3'b010 rise in the same cycle:
   - zone 1 is served first (active_ch=1);
   - zone 2 follows, BEEP_ON entered 2 cycles after zone 1 COOL ends (1 in IDLE).
3. ack pulse mid-BEEP_ON with zone 2 pending:
   - next cycle busy=0, spk_out=0, active_ch=3;
   - zone 2 is never served.
4. ena low for 10 cycles mid-BEEP_OFF:
   - all outputs frozen, spk_out=0;
   - on resume the remaining OFF cycles complete; total busy = 28 + 10 cycles.
5. rst_n low asynchronously mid-BEEP_ON:
   - spk_out, led, busy drop without a clk edge; active_ch=3;
   - after release with alarm_in=0, stays IDLE.
6. BUZZ_PREEMPT_EN defined, zone 2 in its first BEEP_ON, zone 0 rises:
   - at the next tick active_ch=0 and BEEP_ON begins;
   - after zone 0 completes COOL, zone 2 replays its 2 beeps.
